// File: rtl/aes_top_pkg.sv
// Shared definitions for the AES top-level sequencing logic.
//   phase_t        : phase encoding driven on the stepper's phase output
//   LSB_HI/LSB_LO  : slice of the least-significant (displayed) byte in a
//                    128-bit state vector whose bit 0 is the MSB
//   NUM_ROUNDS_DEF : default last round index of each phase
package aes_top_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_ENC  = 2'b01,
        PH_DEC  = 2'b10,
        PH_DONE = 2'b11
    } phase_t;

    localparam int LSB_HI         = 120;
    localparam int LSB_LO         = 127;
    localparam int NUM_ROUNDS_DEF = 10;

endpackage

// File: rtl/aes_round_stepper_dwell_timer.sv
// dwell_timer: counts enabled cycles and flags the last one of each dwell.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear to 0 (wins over en)
//   en       : advance the counter this cycle
//   tick     : high while en=1 and the count sits at DWELL_CYCLES-1; the
//              counter wraps to 0 on that same edge
module dwell_timer #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            // Wraps only through the tick, never free-runs past LAST.
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aes_round_stepper.sv
// aes_round_stepper: walks the shared round index through the encryption
// rounds, then the decryption rounds, holding each for DWELL_CYCLES cycles.
// At the end of every dwell the displayed byte of the active datapath is
// captured; on leaving decryption the deciphered block is compared with the
// plaintext to produce the pass flag.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : run request, honoured only in IDLE or DONE
//   cipher_state    : cipher output (bit 0 = MSB)
//   decipher_state  : decipher output (bit 0 = MSB)
//   plain_text      : reference plaintext for the pass check
//   round           : round index driven to cipher/decipher
//   phase           : 00 IDLE, 01 ENC, 10 DEC, 11 DONE
//   disp_byte       : last captured byte, disp_valid pulses when it updates
//   busy, done      : in ENC/DEC, in DONE
//   pass            : result of the pass check, meaningful while done
module aes_round_stepper
    import aes_top_pkg::*;
#(
    parameter int NUM_ROUNDS   = NUM_ROUNDS_DEF,
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] cipher_state,
    input  logic [0:127] decipher_state,
    input  logic [0:127] plain_text,
    output logic [4:0]   round,
    output logic [1:0]   phase,
    output logic [7:0]   disp_byte,
    output logic         disp_valid,
    output logic         busy,
    output logic         done,
    output logic         pass
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    phase_t     phase_q, phase_nx;
    logic [4:0] round_nx;
    logic [7:0] byte_nx;
    logic       valid_nx;
    logic       pass_nx;
    logic       tick;

    // The dwell counter only runs while busy and is held at 0 otherwise, so a
    // (re)start always begins a full dwell.
    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (!busy),
        .en    (busy),
        .tick  (tick)
    );

    always_comb begin
        phase_nx = phase_q;
        round_nx = round;
        byte_nx  = disp_byte;
        valid_nx = 1'b0;
        pass_nx  = pass;
        case (phase_q)
            PH_IDLE, PH_DONE: begin
                // Restart from DONE clears pass; disp_byte is kept until the
                // first tick of the new run.
                if (start) begin
                    phase_nx = PH_ENC;
                    round_nx = '0;
                    pass_nx  = 1'b0;
                end
            end
            PH_ENC: begin
                if (tick) begin
                    valid_nx = 1'b1;
                    byte_nx  = cipher_state[LSB_HI:LSB_LO];
                    if (round == LAST_ROUND) begin
                        phase_nx = PH_DEC;
                        round_nx = '0;
                    end else begin
                        round_nx = round + 5'd1;
                    end
                end
            end
            PH_DEC: begin
                if (tick) begin
                    valid_nx = 1'b1;
                    byte_nx  = decipher_state[LSB_HI:LSB_LO];
                    if (round == LAST_ROUND) begin
                        // Round stays at the last index through DONE.
                        phase_nx = PH_DONE;
                        pass_nx  = (decipher_state == plain_text);
                    end else begin
                        round_nx = round + 5'd1;
                    end
                end
            end
            default: phase_nx = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            round      <= '0;
            disp_byte  <= '0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            phase_q    <= phase_nx;
            round      <= round_nx;
            disp_byte  <= byte_nx;
            disp_valid <= valid_nx;
            busy       <= (phase_nx == PH_ENC) || (phase_nx == PH_DEC);
            done       <= (phase_nx == PH_DONE);
            pass       <= pass_nx;
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_aes_round_stepper.sv
// Self-checking bench for aes_round_stepper. A time-based model (cycles since
// start accept) predicts every output each cycle; directed literal checks pin
// the model for the documented sequences. A second instance covers the
// single-cycle dwell.
module tb_aes_round_stepper;

    localparam int D   = 4;
    localparam int NR  = 10;
    localparam int TOT = 2 * (NR + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;

    logic [0:127] cipher_state, decipher_state, plain_text, cs1, ds1;
    logic [4:0]   round, round1;
    logic [1:0]   phase, phase1;
    logic [7:0]   disp_byte, byte1;
    logic         disp_valid, busy, done, pass;
    logic         valid1, busy1, done1, pass1;

    logic [119:0] hi_c = '0, hi_d = '0;
    logic [7:0]   enc_base = 8'h10, dec_base = 8'h40;
    int           pt_mode = 0;   // 0: ordinary data, 1: final block = plaintext, 2: plaintext with bit 127 flipped

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign plain_text = 128'h00112233445566778899aabbccddeeff;

    function automatic logic [0:127] cval(input logic [4:0] r, input logic [119:0] hi, input logic [7:0] base);
        return {hi, base + {3'b000, r}};
    endfunction

    function automatic logic [0:127] dval(input logic [4:0] r, input logic [119:0] hi, input logic [7:0] base,
                                          input int mode, input logic [0:127] pt);
        if (mode != 0 && r == 5'(NR))
            return pt ^ ((mode == 2) ? 128'h1 : 128'h0);
        return {hi, base + {3'b000, r}};
    endfunction

    assign cipher_state   = cval(round, hi_c, enc_base);
    assign decipher_state = dval(round, hi_d, dec_base, pt_mode, plain_text);
    assign cs1 = {120'h0, 8'h10 + {3'b000, round1}};
    assign ds1 = (round1 == 5'(NR)) ? plain_text : {120'h0, 8'h40 + {3'b000, round1}};

    aes_round_stepper #(.NUM_ROUNDS(NR), .DWELL_CYCLES(D), .CNT_W(26)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cipher_state(cipher_state), .decipher_state(decipher_state), .plain_text(plain_text),
        .round(round), .phase(phase), .disp_byte(disp_byte), .disp_valid(disp_valid),
        .busy(busy), .done(done), .pass(pass)
    );

    aes_round_stepper #(.NUM_ROUNDS(NR), .DWELL_CYCLES(1), .CNT_W(26)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .cipher_state(cs1), .decipher_state(ds1), .plain_text(plain_text),
        .round(round1), .phase(phase1), .disp_byte(byte1), .disp_valid(valid1),
        .busy(busy1), .done(done1), .pass(pass1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is a span of TOT dwells of D cycles, counted from the accept edge.
    // Dwell k (0-based) is ENC round k for k<=NR, else DEC round k-NR-1.
    bit           m_run, m_done, m_pass, m_valid;
    int           t;
    logic [7:0]   m_byte;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_pass = 0; m_valid = 0; t = 0; m_byte = 8'h00;
        end else begin
            m_valid = 0;
            if (m_run) begin
                t++;
                if (t % D == 0) begin
                    int k, r;
                    logic [0:127] mv;
                    k = t / D - 1;
                    r = k % (NR + 1);
                    mv = (k <= NR) ? cval(5'(r), hi_c, enc_base) : dval(5'(r), hi_d, dec_base, pt_mode, plain_text);
                    m_byte  = mv[120:127];
                    m_valid = 1;
                    if (k == TOT - 1) begin
                        m_run  = 0;
                        m_done = 1;
                        m_pass = (dval(5'(NR), hi_d, dec_base, pt_mode, plain_text) == plain_text);
                    end
                end
            end else if (start) begin
                m_run = 1; t = 0; m_done = 0; m_pass = 0;
            end
        end
    end

    always @(negedge clk) begin
        int ep, er;
        ep = m_run ? ((t / D <= NR) ? 1 : 2) : (m_done ? 3 : 0);
        er = m_run ? ((t / D) % (NR + 1)) : (m_done ? NR : 0);
        check("phase",      32'(phase),      32'(ep));
        check("round",      32'(round),      32'(er));
        check("disp_byte",  32'(disp_byte),  32'(m_byte));
        check("disp_valid", 32'(disp_valid), 32'(m_valid));
        check("busy",       32'(busy),       32'(m_run));
        check("done",       32'(done),       32'(m_done));
        check("pass",       32'(pass),       32'(m_pass));
    end

    // Byte collector for the directed full run.
    bit         collect = 0;
    logic [7:0] q[$];
    always @(negedge clk) if (collect && disp_valid) q.push_back(disp_byte);

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (n < lim) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int n, cnt, vcnt;
        logic [127:0] rnd;

        // Reset
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_round", 32'(round), 32'd0);
        check("rst_byte",  32'(disp_byte), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_pass",  32'(pass), 32'd0);

        // Full run with plain stepping data
        rnd = {$urandom, $urandom, $urandom, $urandom}; hi_c = rnd[119:0];
        rnd = {$urandom, $urandom, $urandom, $urandom}; hi_d = rnd[119:0];
        q.delete();
        collect = 1;
        pulse_start();
        wait_done(200, n);
        @(negedge clk);
        collect = 0;
        check("done_cycle", 32'(n), 32'd88);
        check("valid_count", 32'(q.size()), 32'(TOT));
        for (int i = 0; i < TOT && i < q.size(); i++)
            check("seq_byte", 32'(q[i]), (i <= NR) ? 32'(8'h10 + 8'(i)) : 32'(8'h40 + 8'(i - NR - 1)));
        check("full_pass", 32'(pass), 32'd0);

        // Pass: final deciphered block equals plaintext
        pt_mode = 1;
        pulse_start();
        wait_done(200, n);
        check("pass_hi", 32'(pass), 32'd1);
        check("pass_byte", 32'(disp_byte), 32'hff);

        // Restart from DONE, bit 127 flipped -> fail
        pt_mode = 2;
        pulse_start();
        check("restart_done",  32'(done), 32'd0);
        check("restart_pass",  32'(pass), 32'd0);
        check("restart_phase", 32'(phase), 32'd1);
        check("restart_round", 32'(round), 32'd0);
        check("restart_byte",  32'(disp_byte), 32'hff);
        wait_done(200, n);
        check("fail_pass", 32'(pass), 32'd0);
        check("fail_byte", 32'(disp_byte), 32'hfe);

        // start held high through ENC must not restart
        pt_mode = 0;
        @(negedge clk) start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        check("held_phase", 32'(phase), 32'd1);

        // Async reset at DEC round 5
        cnt = 0;
        while (!(phase == 2'b10 && round == 5'd5) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_dec5", 32'(phase == 2'b10 && round == 5'd5), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_round", 32'(round), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_byte",  32'(disp_byte), 32'd0);
        check("arst_valid", 32'(disp_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_idle", 32'(phase), 32'd0);

        // Randomized runs
        for (int it = 0; it < 4; it++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom}; hi_c = rnd[119:0];
            rnd = {$urandom, $urandom, $urandom, $urandom}; hi_d = rnd[119:0];
            enc_base = 8'($urandom);
            dec_base = 8'($urandom);
            pt_mode  = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            @(negedge clk) start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            wait_done(200, n);
            @(negedge clk);
        end

        // Single-cycle dwell instance
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        n = 0; vcnt = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (valid1) vcnt++;
            if (done1) break;
        end
        check("d1_done_cycle", 32'(n), 32'd22);
        check("d1_valid_cnt",  32'(vcnt), 32'd22);
        check("d1_pass",       32'(pass1), 32'd1);
        check("d1_byte",       32'(byte1), 32'hff);
        check("d1_round",      32'(round1), 32'(NR));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
